logic_bus_arb: RTL and testbench
================================

Name: logic_bus_arb

Overview:
Two-port round-robin arbiter for the 12-bit address / 16-bit data register bus (adr, wr_data, rd_data, wr_req, rd_req, ack). Lets the UART command processor (port 0) and a second on-chip master (port 1, e.g. a sequencer or a second host link) share one set of logic registers. Sits between both masters and the register file; each side sees an ordinary single-master req/ack bus.

Parameters:
P_ADR_W, 12, address width
P_DATA_W, 16, data width
P_TIMEOUT_CNT_MAX, 1023, cycles to wait for m_ack before abort (only with LOGIC_BUS_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s0_adr  in  P_ADR_W  port 0 address
s0_wr_data  in  P_DATA_W  port 0 write data
s0_wr_req  in  1  port 0 write request, level
s0_rd_req  in  1  port 0 read request, level
s0_rd_data  out  P_DATA_W  port 0 read data, valid with s0_ack
s0_ack  out  1  port 0 completion, 1-cycle pulse
s1_*  (same six signals for port 1)
m_adr  out  P_ADR_W  register bus address
m_wr_data  out  P_DATA_W  register bus write data
m_wr_req  out  1  register bus write request
m_rd_req  out  1  register bus read request
m_rd_data  in  P_DATA_W  register bus read data, valid with m_ack
m_ack  in  1  register bus completion pulse
grant  out  1  index of port owning the bus (valid while busy)
busy  out  1  transaction in flight
timeout_err  out  1  1-cycle pulse on aborted transaction

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer favours port 0.
- Master rules: hold req and adr/data stable until ack. Drop req the cycle after ack. wr_req and rd_req asserted together are treated as a write.
- FSM IDLE -> ISSUE -> ACK -> HOLD -> IDLE.
- IDLE:
  - If any sN req is high, pick the winner. Only one requesting wins. If both request, the port not granted last wins.
  - Register adr/wr_data/op and set grant and busy. Go to ISSUE.
- ISSUE:
  - m_wr_req or m_rd_req high from the first ISSUE cycle (1 cycle after request seen), driven from registers.
  - Held until m_ack. On m_ack: capture m_rd_data (reads; writes capture too, ignored), drop m_req next cycle, go to ACK.
- ACK: pulse sN_ack for 1 cycle with sN_rd_data = captured data. Go to HOLD.
- HOLD:
  - 1 cycle; requests ignored so the acked master can drop req. busy clears on return to IDLE.
  - Minimum turnaround request->ack = m_ack latency + 3 cycles.
- sN_rd_data holds its last value between acks. The non-granted port's ack is never asserted.
- m_ack outside ISSUE is ignored.
- A requester that drops req during ISSUE still completes; it receives its ack.
- Async rst mid-transaction: immediate abort, all outputs 0, no ack issued, pointer back to port 0.
- Request lowered before being granted (in IDLE) is simply not serviced.

Optional Feature:
Macro LOGIC_BUS_ARB_TIMEOUT_EN.
- Defined:
  - Counter runs in ISSUE. When it reaches P_TIMEOUT_CNT_MAX without m_ack, drop m_req and go to ACK.
  - Ack the requester with rd_data = 16'hDEAD (low P_DATA_W bits) and pulse timeout_err with the ack.
  - m_ack arriving in the same cycle as expiry wins (normal completion, no error).
- Not defined: ISSUE waits indefinitely; timeout_err tied 0; no counter logic.

Test Plan:
- Single write from s0: s0_adr=12'h010, s0_wr_data=16'h1234, slave acks 2 cycles after m_wr_req -> m_adr=12'h010, m_wr_data=16'h1234, s0_ack one pulse, grant=0, s1_ack never high.
- Single read from s1: s1_adr=12'h0FF, slave returns 16'hBEEF -> s1_rd_data=16'hBEEF with s1_ack; m_rd_req high only during ISSUE.
- Both ports request every cycle from reset, 6 transactions -> grants alternate 0,1,0,1,0,1; each port gets 3 acks; no cycle with both m_wr_req and m_rd_req.
- Port 1 asserts req during port 0's ISSUE -> port 1 granted only after port 0 ack + HOLD; its adr sampled at its own grant.
- rst pulsed while m_wr_req high -> outputs 0 same cycle (async); no s0_ack; next request with both ports high grants port 0.
- With LOGIC_BUS_ARB_TIMEOUT_EN and P_TIMEOUT_CNT_MAX=15, slave never acks -> m_req drops after 15 ISSUE cycles; s0_ack with rd_data=16'hDEAD plus timeout_err pulse; next request serviced normally.

Source files
------------

// File: rtl/logic_bus_arb.sv
// -----------------------------------------------------------------------------
// logic_bus_arb
// Two-port round-robin arbiter for the 12-bit address / 16-bit data register
// bus. Port 0 (UART command processor) and port 1 (second on-chip master)
// each see an ordinary single-master req/ack bus; the arbiter forwards one
// transaction at a time to the shared register file.
//
// Transaction flow: IDLE -> ISSUE -> ACK -> HOLD -> IDLE.
//   IDLE  : pick a winner, latch its address/data/op, raise busy and grant.
//   ISSUE : m_wr_req / m_rd_req held until m_ack, then read data captured.
//   ACK   : one-cycle sN_ack pulse with the captured data on sN_rd_data.
//   HOLD  : one dead cycle so the served master can drop its request.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   sN_adr/sN_wr_data   master N address / write data (N = 0, 1)
//   sN_wr_req/sN_rd_req master N level requests (both high = write)
//   sN_rd_data/sN_ack   master N read data, valid with the 1-cycle ack
//   m_adr/m_wr_data     register bus address / write data
//   m_wr_req/m_rd_req   register bus requests
//   m_rd_data/m_ack     register bus read data / completion pulse
//   grant               index of the port owning the bus (valid while busy)
//   busy                transaction in flight
//   timeout_err         1-cycle pulse with the ack of an aborted transaction
//
// Optional feature: define LOGIC_BUS_ARB_TIMEOUT_EN to abort a transaction
// after P_TIMEOUT_CNT_MAX ISSUE cycles without m_ack. The master then gets an
// ack with read data 16'hDEAD and timeout_err pulses. Without the macro ISSUE
// waits indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module logic_bus_arb #(
  parameter int P_ADR_W           = 12,
  parameter int P_DATA_W          = 16,
  parameter int P_TIMEOUT_CNT_MAX = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [P_ADR_W-1:0]  s0_adr,
  input  logic [P_DATA_W-1:0] s0_wr_data,
  input  logic                s0_wr_req,
  input  logic                s0_rd_req,
  output logic [P_DATA_W-1:0] s0_rd_data,
  output logic                s0_ack,
  input  logic [P_ADR_W-1:0]  s1_adr,
  input  logic [P_DATA_W-1:0] s1_wr_data,
  input  logic                s1_wr_req,
  input  logic                s1_rd_req,
  output logic [P_DATA_W-1:0] s1_rd_data,
  output logic                s1_ack,
  output logic [P_ADR_W-1:0]  m_adr,
  output logic [P_DATA_W-1:0] m_wr_data,
  output logic                m_wr_req,
  output logic                m_rd_req,
  input  logic [P_DATA_W-1:0] m_rd_data,
  input  logic                m_ack,
  output logic                grant,
  output logic                busy,
  output logic                timeout_err
);

  // Elaboration-time parameter sanity check.
  if (P_TIMEOUT_CNT_MAX < 1) begin : g_bad_timeout
    $error("logic_bus_arb: P_TIMEOUT_CNT_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;     // port granted most recently
  logic                  grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic [P_ADR_W-1:0]    adr_q, adr_d;
  logic [P_DATA_W-1:0]   wdata_q, wdata_d;
  logic                  mwr_q, mwr_d;
  logic                  mrd_q, mrd_d;
  logic [P_DATA_W-1:0]   rd0_q, rd0_d;
  logic [P_DATA_W-1:0]   rd1_q, rd1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;

  logic                  req0_s, req1_s, win_s, we_s;

`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
  localparam int             CNT_W  = $clog2(P_TIMEOUT_CNT_MAX + 1);
  localparam logic [15:0]    L_DEAD = 16'hDEAD;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      tmo_q, tmo_d;
  logic                      expire_s;
  // cnt_q counts completed ISSUE cycles; the last allowed cycle sees MAX-1.
  assign expire_s = (cnt_q == CNT_W'(P_TIMEOUT_CNT_MAX - 1));
`endif

  assign req0_s = s0_wr_req | s0_rd_req;
  assign req1_s = s1_wr_req | s1_rd_req;
  // A lone requester wins; with both requesting, the port not served last wins.
  assign win_s  = (req0_s & req1_s) ? ~last_q : req1_s;
  // wr_req and rd_req together count as a write.
  assign we_s   = win_s ? s1_wr_req : s0_wr_req;

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    mwr_d   = mwr_q;
    mrd_d   = mrd_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0_s | req1_s) begin
          state_d = ST_ISSUE;
          last_d  = win_s;
          grant_d = win_s;
          busy_d  = 1'b1;
          adr_d   = win_s ? s1_adr : s0_adr;
          wdata_d = win_s ? s1_wr_data : s0_wr_data;
          mwr_d   = we_s;
          mrd_d   = ~we_s;
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // m_ack wins over a simultaneous expiry.
        if (m_ack) begin
          state_d = ST_ACK;
          mwr_d   = 1'b0;
          mrd_d   = 1'b0;
          if (grant_q) begin
            rd1_d  = m_rd_data;
            ack1_d = 1'b1;
          end else begin
            rd0_d  = m_rd_data;
            ack0_d = 1'b1;
          end
        end
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
        else if (expire_s) begin
          state_d = ST_ACK;
          mwr_d   = 1'b0;
          mrd_d   = 1'b0;
          tmo_d   = 1'b1;
          if (grant_q) begin
            rd1_d  = P_DATA_W'(L_DEAD);
            ack1_d = 1'b1;
          end else begin
            rd0_d  = P_DATA_W'(L_DEAD);
            ack0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = ST_ISSUE;
        end
`endif
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        mwr_d   = 1'b0;
        mrd_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns the pointer to favour port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      mwr_q   <= 1'b0;
      mrd_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      mwr_q   <= mwr_d;
      mrd_q   <= mrd_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign m_adr      = adr_q;
  assign m_wr_data  = wdata_q;
  assign m_wr_req   = mwr_q;
  assign m_rd_req   = mrd_q;
  assign s0_rd_data = rd0_q;
  assign s1_rd_data = rd1_q;
  assign s0_ack     = ack0_q;
  assign s1_ack     = ack1_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_logic_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_logic_bus_arb
// Scoreboard bench for logic_bus_arb. Each master transaction pushes its
// expected completion (read data from a reference memory, timeout flag) into
// a per-port queue; a monitor pops and compares on every sN_ack and checks the
// register-bus side whenever a new request appears on it.
// -----------------------------------------------------------------------------
module tb_logic_bus_arb;
  localparam int AW = 12;
  localparam int DW = 16;
`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
  localparam int TMO = 15;
`else
  localparam int TMO = 1023;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s0_adr, s1_adr, m_adr;
  logic [DW-1:0] s0_wr_data, s1_wr_data, s0_rd_data, s1_rd_data;
  logic          s0_wr_req, s0_rd_req, s1_wr_req, s1_rd_req, s0_ack, s1_ack;
  logic [DW-1:0] m_wr_data, m_rd_data;
  logic          m_wr_req, m_rd_req, m_ack, grant, busy, timeout_err;

  always #5 clk = ~clk;

  logic_bus_arb #(.P_ADR_W(AW), .P_DATA_W(DW), .P_TIMEOUT_CNT_MAX(TMO)) dut (
    .clk(clk), .rst(rst),
    .s0_adr(s0_adr), .s0_wr_data(s0_wr_data), .s0_wr_req(s0_wr_req),
    .s0_rd_req(s0_rd_req), .s0_rd_data(s0_rd_data), .s0_ack(s0_ack),
    .s1_adr(s1_adr), .s1_wr_data(s1_wr_data), .s1_wr_req(s1_wr_req),
    .s1_rd_req(s1_rd_req), .s1_rd_data(s1_rd_data), .s1_ack(s1_ack),
    .m_adr(m_adr), .m_wr_data(m_wr_data), .m_wr_req(m_wr_req),
    .m_rd_req(m_rd_req), .m_rd_data(m_rd_data), .m_ack(m_ack),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          to;
  } txn_t;

  txn_t          exp_q[2][$];
  int            grant_log[$];
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] slv_mem [0:4095];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            last_ack0_cyc = 0;
  int            last_rise_cyc = 0;
  int            last_run = 0;
  bit            slave_hang = 1'b0;
  bit            spurious = 1'b0;
  int            slave_lat = -1;

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic set_port(input int p, input bit wr, input bit rd,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      s0_wr_req = wr; s0_rd_req = rd; s0_adr = a; s0_wr_data = d;
    end else begin
      s1_wr_req = wr; s1_rd_req = rd; s1_adr = a; s1_wr_data = d;
    end
  endtask

  // One master transaction: predict, request, wait for ack, drop request.
  task automatic txn(input int p, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    txn_t e;
    bit   seen;
    e.we = we; e.adr = a; e.wd = d; e.rd = ref_mem[a]; e.to = 1'b0;
    if (slave_hang) begin
      e.rd = 16'hDEAD; e.to = 1'b1;
    end else if (we) begin
      ref_mem[a] = d;
    end
    exp_q[p].push_back(e);
    set_port(p, we, we ? 1'($urandom_range(0, 1)) : 1'b1, a, d);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (p == 0) ? s0_ack : s1_ack;
    end
    set_port(p, 1'b0, 1'b0, a, d);
    if (!seen) check($sformatf("ack_wait_p%0d", p), 1'b0, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Register-file model: memory with configurable ack latency and stray acks.
  initial begin : slave
    int cnt;
    cnt = -1; m_ack = 1'b0; m_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (rst) begin
        cnt = -1;
      end else if (m_wr_req || m_rd_req) begin
        if (!slave_hang) begin
          if (cnt < 0) cnt = (slave_lat >= 0) ? slave_lat : int'($urandom_range(0, 3));
          if (cnt == 0) begin
            m_ack = 1'b1;
            m_rd_data = slv_mem[m_adr];
            if (m_wr_req) slv_mem[m_adr] = m_wr_data;
            cnt = -1;
          end else begin
            cnt--;
          end
        end
      end else begin
        cnt = -1;
        if (spurious && $urandom_range(0, 3) == 0) begin
          m_ack = 1'b1;
          m_rd_data = DW'($urandom);
        end
      end
    end
  end

  // Monitor: bus-side checks on each new request, scoreboard on each ack.
  initial begin : monitor
    bit            prev;
    int            run_len;
    logic [DW-1:0] last_rd [2];
    txn_t          e;
    logic          ackv [2];
    logic [DW-1:0] rdv [2];
    int            g;
    prev = 1'b0; run_len = 0; last_rd[0] = '0; last_rd[1] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev = 1'b0; run_len = 0; last_rd[0] = '0; last_rd[1] = '0;
        continue;
      end
      if (m_wr_req || m_rd_req) begin
        check("m_req_exclusive", !(m_wr_req && m_rd_req), {m_wr_req, m_rd_req}, 64'd1);
        check("busy_in_issue", busy == 1'b1, busy, 64'd1);
        run_len++;
        if (!prev) begin
          g = int'(grant);
          grant_log.push_back(g);
          last_rise_cyc = cyc;
          if (exp_q[g].size() == 0) begin
            check($sformatf("issue_unexpected_p%0d", g), 1'b0, m_adr, 64'd0);
          end else begin
            e = exp_q[g][0];
            check("m_adr", m_adr == e.adr, m_adr, e.adr);
            check("m_op_write", m_wr_req == e.we, m_wr_req, e.we);
            if (e.we) check("m_wr_data", m_wr_data == e.wd, m_wr_data, e.wd);
          end
        end
        prev = 1'b1;
      end else begin
        if (prev) last_run = run_len;
        run_len = 0;
        prev = 1'b0;
      end
      ackv[0] = s0_ack; ackv[1] = s1_ack;
      rdv[0] = s0_rd_data; rdv[1] = s1_rd_data;
      check("single_ack", !(s0_ack && s1_ack), {s0_ack, s1_ack}, 64'd0);
      if (!s0_ack && !s1_ack)
        check("timeout_err_idle", timeout_err == 1'b0, timeout_err, 64'd0);
      for (int p = 0; p < 2; p++) begin
        if (ackv[p]) begin
          if (exp_q[p].size() == 0) begin
            check($sformatf("unexpected_ack_p%0d", p), 1'b0, 64'd1, 64'd0);
          end else begin
            e = exp_q[p].pop_front();
            check($sformatf("rd_data_p%0d", p), rdv[p] == e.rd, rdv[p], e.rd);
            check($sformatf("timeout_err_p%0d", p), timeout_err == e.to, timeout_err, e.to);
          end
          last_rd[p] = rdv[p];
          if (p == 0) last_ack0_cyc = cyc;
        end else begin
          check($sformatf("rd_hold_p%0d", p), rdv[p] == last_rd[p], rdv[p], last_rd[p]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = '0; slv_mem[i] = '0;
    end
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus", {m_wr_req, m_rd_req, m_adr, m_wr_data} == '0,
          {m_wr_req, m_rd_req, m_adr, m_wr_data}, 64'd0);
    check("reset_port", {s0_ack, s1_ack, s0_rd_data, s1_rd_data} == '0,
          {s0_ack, s1_ack, s0_rd_data, s1_rd_data}, 64'd0);
    check("reset_status", {grant, busy, timeout_err} == 3'b000, {grant, busy, timeout_err}, 64'd0);
    rst = 1'b0;

    // Single write from port 0, slave acks two cycles after the request.
    slave_lat = 2;
    grant_log.delete();
    txn(0, 1'b1, 12'h010, 16'h1234);
    check("write_grant", grant_log.size() == 1 && grant_log[0] == 0, grant_log.size(), 64'd1);

    // Port 1 writes BEEF then reads it back.
    slave_lat = -1;
    txn(1, 1'b1, 12'h0FF, 16'hBEEF);
    txn(1, 1'b0, 12'h0FF, 16'h0000);
    check("read_beef", s1_rd_data == 16'hBEEF, s1_rd_data, 64'hBEEF);

    // Both ports requesting continuously from reset: grants alternate.
    pulse_reset();
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) txn(0, 1'($urandom_range(0, 1)), 12'h020 + 12'(i), 16'($urandom));
      end
      begin
        for (int i = 0; i < 3; i++) txn(1, 1'($urandom_range(0, 1)), 12'h820 + 12'(i), 16'($urandom));
      end
    join
    check("alt_count", grant_log.size() == 6, grant_log.size(), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("alt_grant_%0d", i), grant_log[i] == (i % 2), grant_log[i], i % 2);

    // Port 1 requests during port 0's ISSUE: served after ACK + HOLD.
    slave_lat = 3;
    fork
      txn(0, 1'b1, 12'h030, 16'h5A5A);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk); #1;
          seen = m_wr_req;
        end
        check("late_wait", seen, seen, 64'd1);
        txn(1, 1'b0, 12'h830, 16'h0000);
      end
    join
    check("late_grant_gap", last_rise_cyc - last_ack0_cyc == 3, last_rise_cyc - last_ack0_cyc, 64'd3);

    // Asynchronous reset while a port 0 write is on the bus.
    slave_lat = 10;
    begin
      txn_t e;
      e.we = 1'b1; e.adr = 12'h123; e.wd = 16'hCAFE; e.rd = '0; e.to = 1'b0;
      exp_q[0].push_back(e);
    end
    set_port(0, 1'b1, 1'b0, 12'h123, 16'hCAFE);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = m_wr_req;
    end
    check("rst_issue_seen", seen, seen, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_bus", {m_wr_req, m_rd_req, m_adr, m_wr_data} == '0,
          {m_wr_req, m_rd_req, m_adr, m_wr_data}, 64'd0);
    check("arst_port", {s0_ack, s1_ack, s0_rd_data, s1_rd_data} == '0,
          {s0_ack, s1_ack, s0_rd_data, s1_rd_data}, 64'd0);
    check("arst_status", {grant, busy, timeout_err} == 3'b000, {grant, busy, timeout_err}, 64'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    exp_q[0].delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    slave_lat = -1;
    grant_log.delete();
    fork
      txn(0, 1'b0, 12'h010, 16'h0000);
      txn(1, 1'b0, 12'h0FF, 16'h0000);
    join
    check("post_rst_grant", grant_log.size() == 2 && grant_log[0] == 0, grant_log[0], 64'd0);

`ifdef LOGIC_BUS_ARB_TIMEOUT_EN
    // Slave never answers: abort after TMO ISSUE cycles with DEAD data.
    slave_hang = 1'b1;
    txn(0, 1'b0, 12'h050, 16'h0000);
    check("timeout_issue_len", last_run == TMO, last_run, TMO);
    slave_hang = 1'b0;
    txn(0, 1'b1, 12'h050, 16'h7777);
    txn(0, 1'b0, 12'h050, 16'h0000);
`endif

    // Randomised traffic with stray m_ack pulses outside ISSUE.
    spurious = 1'b1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          txn(0, 1'($urandom_range(0, 1)), 12'h040 + 12'($urandom_range(0, 7)), 16'($urandom));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          txn(1, 1'($urandom_range(0, 1)), 12'h840 + 12'($urandom_range(0, 7)), 16'($urandom));
        end
      end
    join
    spurious = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drain_p0", exp_q[0].size() == 0, exp_q[0].size(), 64'd0);
    check("drain_p1", exp_q[1].size() == 0, exp_q[1].size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
